// File: rtl/weight_stabilizer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pkg_sorter_defs
// Description : Definitions shared between the weight stabilizer and the
//               package sorter: FSM state encoding and the default width of
//               the Weight word exchanged between the two blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package pkg_sorter_defs;

    // Default width of raw and stabilized weight words.
    localparam int C_W_BITS = 12;

    // Width of the qualification / release counters.
    localparam int C_CNT_BITS = 4;

    // Stabilizer FSM states, explicitly encoded.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

endpackage : pkg_sorter_defs
`default_nettype wire

// File: rtl/weight_stabilizer_abs_diff_le.sv
`default_nettype none
// ============================================================================
// Module      : abs_diff_le
// Description : Combinational tolerance comparator. Asserts o_le when
//               |i_a - i_b| <= TOL. The difference is formed one bit wider
//               than the operands and treated as signed, so it never wraps.
// Ports       : i_a  [W_BITS-1:0]  first operand (unsigned)
//               i_b  [W_BITS-1:0]  second operand (unsigned)
//               o_le               1 when the absolute difference <= TOL
// Revision    : 1.0 - initial release
// ============================================================================
module abs_diff_le #(
    parameter int W_BITS = 12,
    parameter int TOL    = 8
) (
    input  logic [W_BITS-1:0] i_a,
    input  logic [W_BITS-1:0] i_b,
    output logic              o_le
);

    localparam logic [W_BITS:0] C_TOL = (W_BITS + 1)'(TOL);

    logic signed [W_BITS:0] w_diff;
    logic        [W_BITS:0] w_abs;

    // Zero-extend both operands before subtracting; the MSB of the result is
    // then a true sign bit and the magnitude fits in W_BITS+1 bits.
    assign w_diff = $signed({1'b0, i_a}) - $signed({1'b0, i_b});
    assign w_abs  = w_diff[W_BITS] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign o_le   = (w_abs <= C_TOL);

endmodule : abs_diff_le
`default_nettype wire

// File: rtl/weight_stabilizer.sv
`default_nettype none
// ============================================================================
// Module      : weight_stabilizer
// Description : Conditions raw scale samples into a single settled weight per
//               package. A package is accepted after STABLE_CNT consecutive
//               valid samples stay within TOL of the first sample of the
//               window; the accepted weight is held until EMPTY_CNT
//               consecutive empty samples are seen, then Weight returns to 0.
//               Exactly one 0 -> nonzero transition occurs per package.
// Ports       : CLK          system clock, rising edge
//               Reset        synchronous active-low reset
//               RawWeight    unfiltered scale sample   [W_BITS-1:0]
//               SampleValid  RawWeight carries a new sample this cycle
//               Weight       stabilized weight, 0 when nothing accepted
//               Stable       1 while holding an accepted weight
//               Settling     1 while qualifying a package
//               Restart      1-cycle pulse when a settle window is discarded
// Revision    : 1.0 - initial release
// ============================================================================
module weight_stabilizer
    import pkg_sorter_defs::*;
#(
    parameter int W_BITS     = C_W_BITS,
    parameter int STABLE_CNT = 4,
    parameter int TOL        = 8,
    parameter int ZERO_THR   = 4,
    parameter int EMPTY_CNT  = 3
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [W_BITS-1:0] RawWeight,
    input  logic              SampleValid,
    output logic [W_BITS-1:0] Weight,
    output logic              Stable,
    output logic              Settling,
    output logic              Restart
);

    localparam logic [C_CNT_BITS-1:0] C_STABLE_CNT = C_CNT_BITS'(STABLE_CNT);
    localparam logic [C_CNT_BITS-1:0] C_EMPTY_CNT  = C_CNT_BITS'(EMPTY_CNT);
    localparam logic [C_CNT_BITS-1:0] C_CNT_ONE    = C_CNT_BITS'(1);
    localparam logic [W_BITS-1:0]     C_ZERO_THR   = W_BITS'(ZERO_THR);

    // ------------------------------------------------------------------------
    // Registered state and datapath
    // ------------------------------------------------------------------------
    state_t                  r_state;
    logic [W_BITS-1:0]       r_ref;      // first sample of the current window
    logic [C_CNT_BITS-1:0]   r_run;      // qualifying samples in the window
    logic [C_CNT_BITS-1:0]   r_empty;    // consecutive empty samples in HOLD
    logic [W_BITS-1:0]       r_weight;
    logic                    r_restart;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t                  w_state_nxt;
    logic [W_BITS-1:0]       w_ref_nxt;
    logic [C_CNT_BITS-1:0]   w_run_nxt;
    logic [C_CNT_BITS-1:0]   w_empty_nxt;
    logic [W_BITS-1:0]       w_weight_nxt;
    logic                    w_restart_nxt;

    logic                    w_is_empty;
    logic                    w_in_tol;
    logic [C_CNT_BITS-1:0]   w_run_inc;
    logic [C_CNT_BITS-1:0]   w_empty_inc;

    assign w_is_empty  = (RawWeight <= C_ZERO_THR);
    assign w_run_inc   = r_run + C_CNT_ONE;
    assign w_empty_inc = r_empty + C_CNT_ONE;

    abs_diff_le #(
        .W_BITS (W_BITS),
        .TOL    (TOL)
    ) u_tol_cmp (
        .i_a  (RawWeight),
        .i_b  (r_ref),
        .o_le (w_in_tol)
    );

    // ------------------------------------------------------------------------
    // State / datapath register
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_ref     <= '0;
            r_run     <= '0;
            r_empty   <= '0;
            r_weight  <= '0;
            r_restart <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ref     <= w_ref_nxt;
            r_run     <= w_run_nxt;
            r_empty   <= w_empty_nxt;
            r_weight  <= w_weight_nxt;
            r_restart <= w_restart_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. Cycles without a valid sample hold everything and
    // only drop the Restart pulse.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_ref_nxt     = r_ref;
        w_run_nxt     = r_run;
        w_empty_nxt   = r_empty;
        w_weight_nxt  = r_weight;
        w_restart_nxt = 1'b0;

        if (SampleValid) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_is_empty) begin
                        // The opening sample becomes the window reference
                        // and counts as the first qualifying sample.
                        w_ref_nxt   = RawWeight;
                        w_run_nxt   = C_CNT_ONE;
                        w_state_nxt = ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    if (w_is_empty) begin
                        // Package lifted before settling: silent abandon.
                        w_run_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else if (!w_in_tol) begin
                        // Still bouncing: restart the window on this sample.
                        w_ref_nxt     = RawWeight;
                        w_run_nxt     = C_CNT_ONE;
                        w_restart_nxt = 1'b1;
                    end else begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == C_STABLE_CNT) begin
                            // Publish the reference, not the latest sample,
                            // so the accepted value is the window anchor.
                            w_weight_nxt = r_ref;
                            w_empty_nxt  = '0;
                            w_state_nxt  = ST_HOLD;
                        end
                    end
                end

                ST_HOLD: begin
                    if (w_is_empty) begin
                        w_empty_nxt = w_empty_inc;
                        if (w_empty_inc == C_EMPTY_CNT) begin
                            w_weight_nxt = '0;
                            w_run_nxt    = '0;
                            w_state_nxt  = ST_IDLE;
                        end
                    end else begin
                        // Any load on the platform keeps the held weight;
                        // a swapped package is intentionally not re-weighed.
                        w_empty_nxt = '0;
                    end
                end

                default: begin
                    w_weight_nxt = '0;
                    w_run_nxt    = '0;
                    w_empty_nxt  = '0;
                    w_state_nxt  = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output decode from registered state
    // ------------------------------------------------------------------------
    always_comb begin
        Stable   = (r_state == ST_HOLD);
        Settling = (r_state == ST_SETTLE);
    end

    assign Weight  = r_weight;
    assign Restart = r_restart;

endmodule : weight_stabilizer
`default_nettype wire

// File: tb/tb_weight_stabilizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_weight_stabilizer
// Description : Self-checking bench for weight_stabilizer. A table of
//               directed vectors with hand-derived expectations, followed by
//               a randomized run checked against a sample-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_stabilizer;

    localparam int W  = 12;
    localparam int SC = 4;
    localparam int TL = 8;
    localparam int ZT = 4;
    localparam int EC = 3;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [W-1:0]  RawWeight;
    logic          SampleValid;
    logic [W-1:0]  Weight;
    logic          Stable;
    logic          Settling;
    logic          Restart;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    weight_stabilizer #(
        .W_BITS     (W),
        .STABLE_CNT (SC),
        .TOL        (TL),
        .ZERO_THR   (ZT),
        .EMPTY_CNT  (EC)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .RawWeight   (RawWeight),
        .SampleValid (SampleValid),
        .Weight      (Weight),
        .Stable      (Stable),
        .Settling    (Settling),
        .Restart     (Restart)
    );

    typedef struct {
        logic         rstn;
        logic         valid;
        logic [W-1:0] raw;
        logic [W-1:0] w;
        logic         st;
        logic         se;
        logic         rs;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rstn, input logic valid, input int raw,
                       input int w, input logic st, input logic se, input logic rs);
        vec_t v;
        v.rstn = rstn; v.valid = valid; v.raw = W'(raw);
        v.w = W'(w); v.st = st; v.se = se; v.rs = rs;
        tbl.push_back(v);
    endtask

    // Drive one cycle: inputs set #1 after the previous edge, sampled one
    // edge later, outputs checked #1 after that edge.
    task automatic drive(input logic rstn, input logic valid, input logic [W-1:0] raw);
        Reset = rstn; SampleValid = valid; RawWeight = raw;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] w,
                         input logic st, input logic se, input logic rs);
        total++;
        if (Weight !== w || Stable !== st || Settling !== se || Restart !== rs) begin
            bad++;
            $display("FAIL %s: got w=%0d st=%0b se=%0b rs=%0b, expected w=%0d st=%0b se=%0b rs=%0b",
                     name, Weight, Stable, Settling, Restart, w, st, se, rs);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: a package is either held (m_held != 0), being
    // qualified (m_len > 0 samples since m_ref), or absent.
    // ------------------------------------------------------------------------
    int m_held, m_ref, m_len, m_zeros;
    bit m_restart;

    task automatic model_step(input logic rstn, input logic valid, input int raw);
        m_restart = 0;
        if (!rstn) begin
            m_held = 0; m_ref = 0; m_len = 0; m_zeros = 0;
        end else if (valid) begin
            if (m_held != 0) begin
                if (raw <= ZT) begin
                    m_zeros++;
                    if (m_zeros == EC) begin m_held = 0; m_zeros = 0; end
                end else m_zeros = 0;
            end else if (m_len == 0) begin
                if (raw > ZT) begin m_ref = raw; m_len = 1; end
            end else if (raw <= ZT) begin
                m_len = 0;
            end else if ((raw > m_ref ? raw - m_ref : m_ref - raw) > TL) begin
                m_ref = raw; m_len = 1; m_restart = 1;
            end else begin
                m_len++;
                if (m_len == SC) begin m_held = m_ref; m_len = 0; m_zeros = 0; end
            end
        end
    endtask

    initial begin
        int base;
        int raw;
        logic v, r;

        Reset = 1'b0; SampleValid = 1'b0; RawWeight = '0;

        // Reset, including a valid sample that must be ignored.
        add(0,1,500,  0,0,0,0);
        add(0,0,0,    0,0,0,0);
        add(1,1,0,    0,0,0,0); add(1,1,0, 0,0,0,0); add(1,1,0, 0,0,0,0);
        // Basic accept and release.
        add(1,1,300,  0,0,1,0); add(1,1,305, 0,0,1,0); add(1,1,298, 0,0,1,0);
        add(1,1,302,  300,1,0,0);
        add(1,1,0,    300,1,0,0); add(1,1,0, 300,1,0,0); add(1,1,0, 0,0,0,0);
        // Restart on bounce; idle cycle clears the pulse and holds the count.
        add(1,1,300,  0,0,1,0); add(1,1,305, 0,0,1,0); add(1,1,400, 0,0,1,1);
        add(1,0,999,  0,0,1,0); add(1,1,402, 0,0,1,0); add(1,1,399, 0,0,1,0);
        add(1,1,401,  400,1,0,0);
        add(1,1,0,    400,1,0,0); add(1,1,0, 400,1,0,0); add(1,1,0, 0,0,0,0);
        // Empty count cleared by a nonzero sample while holding.
        add(1,1,1500, 0,0,1,0); add(1,1,1500, 0,0,1,0); add(1,1,1500, 0,0,1,0);
        add(1,1,1500, 1500,1,0,0);
        add(1,1,0,    1500,1,0,0); add(1,1,0, 1500,1,0,0);
        add(1,1,1500, 1500,1,0,0);
        add(1,1,0,    1500,1,0,0); add(1,1,0, 1500,1,0,0);
        add(1,0,0,    1500,1,0,0);
        add(1,1,0,    0,0,0,0);    add(1,1,0, 0,0,0,0);
        // Full-scale weight.
        add(1,1,4095, 0,0,1,0); add(1,1,4095, 0,0,1,0); add(1,1,4095, 0,0,1,0);
        add(1,1,4095, 4095,1,0,0);
        add(1,1,2,    4095,1,0,0); add(1,1,4, 4095,1,0,0); add(1,1,1, 0,0,0,0);
        // Abandon settle on empty sample without Restart.
        add(1,1,500,  0,0,1,0); add(1,1,3, 0,0,0,0);
        // Zero threshold boundary: 5 is a package, 4 is empty.
        add(1,1,5,    0,0,1,0); add(1,1,4, 0,0,0,0);
        // Tolerance boundary: +/-8 accepted, +9 restarts.
        add(1,1,1000, 0,0,1,0); add(1,1,1008, 0,0,1,0); add(1,1,992, 0,0,1,0);
        add(1,1,1009, 0,0,1,1); add(1,1,1009, 0,0,1,0); add(1,1,1001, 0,0,1,0);
        add(1,1,1017, 1009,1,0,0);
        // A different load while holding is not re-weighed.
        add(1,1,2000, 1009,1,0,0);
        add(1,1,0,    1009,1,0,0); add(1,1,0, 1009,1,0,0); add(1,1,0, 0,0,0,0);
        // Reset mid-hold with a simultaneous valid sample.
        add(1,1,800,  0,0,1,0); add(1,1,800, 0,0,1,0); add(1,1,800, 0,0,1,0);
        add(1,1,800,  800,1,0,0);
        add(0,1,0,    0,0,0,0);
        add(1,0,0,    0,0,0,0);
        // Reset mid-settle with an in-tolerance sample.
        add(1,1,700,  0,0,1,0); add(1,1,700, 0,0,1,0); add(1,1,700, 0,0,1,0);
        add(0,1,700,  0,0,0,0); add(1,1,700, 0,0,1,0);

        @(posedge CLK); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rstn, tbl[i].valid, tbl[i].raw);
            check($sformatf("vec%0d", i), tbl[i].w, tbl[i].st, tbl[i].se, tbl[i].rs);
        end

        // Randomized run against the model, starting from reset.
        drive(1'b0, 1'b0, '0);
        model_step(1'b0, 1'b0, 0);
        check("rand_reset", 0, 0, 0, 0);
        base = 1000;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 299) != 0);
            v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) base = $urandom_range(5, 4095);
            case ($urandom_range(0, 9))
                0, 1:    raw = $urandom_range(0, ZT);
                2:       raw = $urandom_range(0, 4095);
                3:       raw = ZT + 1;
                default: begin
                    raw = base + $urandom_range(0, 10) - 5;
                    if (raw > 4095) raw = 4095;
                    if (raw < 0) raw = 0;
                end
            endcase
            drive(r, v, W'(raw));
            model_step(r, v, raw);
            check($sformatf("rand%0d", n), W'(m_held), m_held != 0, m_len > 0, m_restart);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_weight_stabilizer
`default_nettype wire

// File: doc/weight_stabilizer.md
Name: weight_stabilizer

Overview:
- Upstream stage of the package sorter. Conditions raw scale samples into the clean Weight word the sorter consumes.
- Suppresses load-cell bounce while a package lands. Presents a single settled nonzero weight per package, held steady until the platform empties, then returns to exactly 0.
- Guarantees exactly one 0 -> nonzero transition per package, which is the sorter's new-item trigger.

Parameters:
- W_BITS, 12, width of raw and stabilized weight.
- STABLE_CNT, 4, consecutive in-tolerance valid samples needed to accept a weight (2..15).
- TOL, 8, max absolute deviation from the window reference sample, in weight units.
- ZERO_THR, 4, raw samples <= ZERO_THR count as empty platform.
- EMPTY_CNT, 3, consecutive empty valid samples needed to release a held weight (1..15).

Ports:
- CLK  in  1  system clock; all logic on posedge CLK.
- Reset  in  1  synchronous, active-low reset (0 = reset), sampled on posedge CLK.
- RawWeight  in  W_BITS  unfiltered scale/ADC sample.
- SampleValid  in  1  RawWeight is a new sample this cycle; ignored when 0.
- Weight  out  W_BITS  stabilized weight to the sorter; 0 when no package is accepted.
- Stable  out  1  1 while a weight is being held (state HOLD).
- Settling  out  1  1 while qualifying a package (state SETTLE).
- Restart  out  1  one-cycle pulse when a SETTLE window is discarded because a sample fell out of tolerance.

Behaviour:
- Reset (Reset=0 at posedge CLK) sets state to IDLE, Weight=0, Stable=0, Settling=0, Restart=0, ref=0, run counter=0, empty counter=0. Reset wins over any simultaneous sample, including mid-SETTLE or mid-HOLD. Weight drops to 0 on that edge.
- All outputs are registered. Stable and Settling are decoded from the registered state.
- Cycles with SampleValid=0 change nothing: counters and state hold, and Restart=0.
- "Empty sample" means a valid sample with RawWeight <= ZERO_THR.
- "In tolerance" means |RawWeight - ref| <= TOL, computed with a W_BITS+1-bit signed difference. No wrap-around.
- State IDLE (Weight=0):
  - A valid non-empty sample sets ref <= RawWeight and run <= 1, then goes to SETTLE.
  - Empty samples stay in IDLE.
- State SETTLE (Weight=0):
  - Empty sample -> IDLE, run <= 0, no Restart pulse.
  - Out-of-tolerance non-empty sample -> ref <= RawWeight, run <= 1, Restart=1 for one cycle, stay in SETTLE.
  - In-tolerance sample -> run <= run+1. If run+1 == STABLE_CNT: Weight <= ref, go to HOLD, empty <= 0.
  - Latency: Weight becomes valid on the same edge that registers the STABLE_CNT-th qualifying sample.
- State HOLD (Weight=ref, constant):
  - Empty sample -> empty <= empty+1. If empty+1 == EMPTY_CNT: Weight <= 0, go to IDLE, run <= 0.
  - Non-empty sample of any value -> empty <= 0. There is no re-weigh in HOLD; a package swapped without emptying the platform is not re-measured.
- Weight is never nonzero outside HOLD.
- The accepted value is always > ZERO_THR, so it is never 0.
- Counters saturate at 4 bits and cannot wrap, given the parameter bounds above.

Decomposition:
- Shared package (pkg_sorter_defs): the state enum (IDLE, SETTLE, HOLD) and the W_BITS default, shared with the sorter's Weight width.
- One sub-module: abs_diff_le, a combinational |a-b| <= TOL comparator parameterized by W_BITS and TOL. Everything else stays in this module.

Test Plan:
- Reset=0 for 2 cycles, then valid samples 0,0,0 -> Weight=0, Stable=0, Settling=0 throughout.
- Valid 300,305,298,302 (default params) -> Settling=1 after the first sample; Weight=300 and Stable=1 on the edge of the 4th sample. Then 0,0,0 -> Weight=0 on the 3rd zero, back to IDLE.
- Valid 300,305,400,402,399,401 -> Restart pulses once on sample 400; Weight=400 after sample 401. Weight is 0 during every earlier cycle.
- In HOLD at 1500: samples 0,0,1500,0,0 -> empty count resets and Weight stays 1500; two more zeros -> Weight=0.
- Valid 4095 x4 -> Weight=4095 (no overflow). Valid 500,3 in SETTLE -> IDLE with no Restart pulse.
- Assert Reset=0 mid-HOLD (Weight=800) with SampleValid=1 on the same edge -> Weight=0 and state IDLE next cycle; the sample is ignored.
